// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl -- instruction-cache miss handling and line refill.
// On a lookup miss the controller latches the address and a round-robin
// victim way, requests the line from memory, writes each returned word into
// the data RAM, and finally writes the tag and valid bit for the victim way.
// Optional build macro: ICACHE_REFILL_PERF_EN adds a saturating miss counter
// on output miss_cnt.
module icache_refill_ctrl #(
  parameter int WAY_NUM    = 4,
  parameter int LINE_WORDS = 8,
  parameter int INDEX_W    = 7
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        req_valid,
  input  logic [31:0]                                 req_addr,
  input  logic                                        lookup_hit,
  output logic                                        stall,
  output logic                                        rd_req,
  output logic [31:0]                                 rd_addr,
  input  logic                                        rd_rdy,
  input  logic                                        ret_valid,
  input  logic [31:0]                                 ret_data,
  output logic                                        wr_en,
  output logic [$clog2(WAY_NUM)-1:0]                  wr_way,
  output logic [INDEX_W-1:0]                          wr_index,
  output logic [$clog2(LINE_WORDS)-1:0]               wr_offset,
  output logic [31:0]                                 wr_data,
  output logic                                        tag_wr,
  output logic [32-INDEX_W-$clog2(LINE_WORDS)-2-1:0]  tag_data,
`ifdef ICACHE_REFILL_PERF_EN
  output logic [31:0]                                 miss_cnt,
`endif
  output logic                                        refill_done
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int WAY_W  = $clog2(WAY_NUM);
  localparam int IDX_LO = OFF_W + 2;              // first index bit above the byte offset
  localparam int TAG_W  = 32 - INDEX_W - IDX_LO;

  typedef enum logic [1:0] {IDLE, MISS, REFILL, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      addr_q;
  logic [WAY_W-1:0] victim_ptr;
  logic [WAY_W-1:0] victim_q;
  logic [OFF_W-1:0] word_cnt;
  logic             miss_start;
  logic             last_word;

  assign miss_start = (state == IDLE) && req_valid && !lookup_hit;
  assign last_word  = (state == REFILL) && ret_valid && (word_cnt == OFF_W'(LINE_WORDS - 1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; stray handshakes outside their state fall through.
  always_comb begin
    // NOTE: assigning a default before the case keeps this purely
    // combinational; a missed branch would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (miss_start) state_nxt = MISS;
      MISS:    if (rd_rdy)     state_nxt = REFILL;
      REFILL:  if (last_word)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Miss context, word counter and round-robin victim pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      victim_q   <= '0;
      victim_ptr <= '0;
      word_cnt   <= '0;
    end else begin
      if (miss_start) begin
        addr_q   <= req_addr;
        victim_q <= victim_ptr;
      end
      if (state == REFILL && ret_valid) word_cnt <= word_cnt + 1'b1;
      else if (state == DONE)           word_cnt <= '0;
      if (state == DONE)
        victim_ptr <= (victim_ptr == WAY_W'(WAY_NUM - 1)) ? '0 : victim_ptr + 1'b1;
    end
  end

`ifdef ICACHE_REFILL_PERF_EN
  // Saturating count of IDLE->MISS transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         miss_cnt <= '0;
    else if (miss_start && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
  end
`endif

  // Output decode; address/data fields are zero except while they qualify a strobe.
  always_comb begin
    stall       = 1'b0;
    rd_req      = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_way      = '0;
    wr_index    = '0;
    wr_offset   = '0;
    wr_data     = '0;
    tag_wr      = 1'b0;
    tag_data    = '0;
    refill_done = 1'b0;
    unique case (state)
      IDLE: stall = req_valid && !lookup_hit && !rst;
      MISS: begin
        stall   = 1'b1;
        rd_req  = 1'b1;
        rd_addr = {addr_q[31:IDX_LO], {IDX_LO{1'b0}}};
      end
      REFILL: begin
        stall = 1'b1;
        if (ret_valid) begin
          wr_en     = 1'b1;
          wr_way    = victim_q;
          wr_index  = addr_q[IDX_LO +: INDEX_W];
          wr_offset = word_cnt;
          wr_data   = ret_data;
        end
      end
      DONE: begin
        stall       = 1'b1;
        tag_wr      = 1'b1;
        refill_done = 1'b1;
        wr_way      = victim_q;
        wr_index    = addr_q[IDX_LO +: INDEX_W];
        tag_data    = addr_q[31 -: TAG_W];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl -- randomized self-checking bench for icache_refill_ctrl.
// Expected values come from address arithmetic and a transaction-level model
// (victim way counter, miss counter). Define ICACHE_REFILL_PERF_EN to also
// check miss_cnt.
module tb_icache_refill_ctrl;

  localparam int WAY_NUM    = 4;
  localparam int LINE_WORDS = 8;
  localparam int INDEX_W    = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, lookup_hit, rd_rdy, ret_valid;
  logic [31:0] req_addr, ret_data;
  logic        stall, rd_req, wr_en, tag_wr, refill_done;
  logic [31:0] rd_addr, wr_data;
  logic [1:0]  wr_way;
  logic [6:0]  wr_index;
  logic [2:0]  wr_offset;
  logic [19:0] tag_data;
`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] miss_cnt;
`endif

  icache_refill_ctrl #(.WAY_NUM(WAY_NUM), .LINE_WORDS(LINE_WORDS), .INDEX_W(INDEX_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .lookup_hit(lookup_hit),
    .stall(stall), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_en(wr_en), .wr_way(wr_way), .wr_index(wr_index), .wr_offset(wr_offset),
    .wr_data(wr_data), .tag_wr(tag_wr), .tag_data(tag_data),
`ifdef ICACHE_REFILL_PERF_EN
    .miss_cnt(miss_cnt),
`endif
    .refill_done(refill_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int model_victim = 0;
  int model_misses = 0;
  int way_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    lookup_hit = 1'b0;
    rd_rdy     = 1'b0;
    ret_valid  = 1'b0;
    req_addr   = $urandom;
    ret_data   = $urandom;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_strobes"}, 32'({stall, rd_req, wr_en, tag_wr, refill_done}), 32'd0);
    check({tag, "_rd_addr"}, rd_addr, 32'd0);
    check({tag, "_wr_fields"}, 32'({wr_way, wr_index, wr_offset}), 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_tag_data"}, 32'(tag_data), 32'd0);
  endtask

  // Assert reset at a falling edge, check quiescent outputs, then release.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1 check_quiet("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_victim = 0;
    model_misses = 0;
  endtask

  // One idle-state cycle: a hit lookup and/or stray memory handshakes.
  task automatic do_idle_cycle(input logic [31:0] addr, input bit hit, input bit stray);
    @(negedge clk);
    idle_inputs();
    req_valid  = hit;
    lookup_hit = hit;
    req_addr   = addr;
    ret_valid  = stray;
    rd_rdy     = stray;
    #1;
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_rd_req", 32'(rd_req), 32'd0);
    check("idle_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("idle_after_rd_req", 32'(rd_req), 32'd0);
    check("idle_after_stall", 32'(stall), 32'd0);
    check("idle_after_tag_wr", 32'(tag_wr), 32'd0);
  endtask

  // Full miss transaction. gap_mode: 0 back-to-back words, 1 one-cycle gaps,
  // 2 random gaps. abort_after >= 0 resets right after that many words.
  task automatic do_miss(input logic [31:0] addr, input int rdy_dly,
                         input int gap_mode, input int abort_after);
    logic [31:0] exp_rd  = addr & 32'hFFFF_FFE0;
    logic [31:0] exp_idx = (addr >> 5) & 32'h7F;
    logic [31:0] exp_tag = addr >> 12;
    logic [31:0] exp_way = 32'(model_victim);
    int words = 0;
    int cyc   = 0;

    @(negedge clk);
    idle_inputs();
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    check("miss_stall_comb", 32'(stall), 32'd1);
    check("miss_no_rd_yet", 32'(rd_req), 32'd0);
    model_misses++;

    for (int i = 0; i <= rdy_dly; i++) begin
      @(negedge clk);
      req_valid  = 1'($urandom);
      lookup_hit = 1'($urandom);
      req_addr   = $urandom;
      ret_valid  = 1'($urandom);
      ret_data   = $urandom;
      rd_rdy     = (i == rdy_dly);
      #1;
      check("miss_rd_req", 32'(rd_req), 32'd1);
      check("miss_rd_addr", rd_addr, exp_rd);
      check("miss_no_wr", 32'(wr_en), 32'd0);
      check("miss_stall", 32'(stall), 32'd1);
    end

    while (words < LINE_WORDS && cyc < 200) begin
      @(negedge clk);
      req_valid = 1'($urandom);
      req_addr  = $urandom;
      rd_rdy    = 1'($urandom);
      ret_data  = $urandom;
      case (gap_mode)
        0:       ret_valid = 1'b1;
        1:       ret_valid = (cyc % 2 == 0);
        default: ret_valid = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      if (ret_valid) begin
        check("refill_wr_en", 32'(wr_en), 32'd1);
        check("refill_offset", 32'(wr_offset), 32'(words));
        check("refill_way", 32'(wr_way), exp_way);
        check("refill_index", 32'(wr_index), exp_idx);
        check("refill_data", wr_data, ret_data);
        words++;
      end else begin
        check("refill_gap_no_wr", 32'(wr_en), 32'd0);
      end
      check("refill_no_tag_wr", 32'(tag_wr), 32'd0);
      check("refill_stall", 32'(stall), 32'd1);
      cyc++;
      if (words == abort_after) begin
        do_reset();
        return;
      end
    end
    if (cyc >= 200) check("refill_timeout", 32'd1, 32'd0);

    @(negedge clk);
    idle_inputs();
    ret_valid = 1'b1;
    rd_rdy    = 1'b1;
    #1;
    check("done_tag_wr", 32'(tag_wr), 32'd1);
    check("done_refill_done", 32'(refill_done), 32'd1);
    check("done_tag_data", 32'(tag_data), exp_tag);
    check("done_way", 32'(wr_way), exp_way);
    check("done_index", 32'(wr_index), exp_idx);
    check("done_no_wr", 32'(wr_en), 32'd0);
    check("done_stall", 32'(stall), 32'd1);
    way_log.push_back(int'(wr_way));
    model_victim = (model_victim + 1) % WAY_NUM;

    @(negedge clk);
    idle_inputs();
    #1;
    check("post_tag_wr", 32'(tag_wr), 32'd0);
    check("post_refill_done", 32'(refill_done), 32'd0);
    check("post_stall", 32'(stall), 32'd0);
    check("post_rd_req", 32'(rd_req), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // Hit and stray handshakes in IDLE.
    do_idle_cycle(32'h0000_1000, 1'b1, 1'b0);
    do_idle_cycle($urandom, 1'b0, 1'b1);

    // Directed miss with a two-cycle accept delay and gapped returns.
    way_log.delete();
    do_miss(32'h0000_1234, 2, 1, -1);

    // Four more misses: five in total give the round-robin sequence.
    for (int i = 0; i < 4; i++) do_miss($urandom, $urandom_range(0, 3), 0, -1);
    for (int i = 0; i < 5; i++) check($sformatf("rr_way_%0d", i), 32'(way_log[i]), 32'(exp_seq[i]));

    // Reset after the third returned word; the next miss restarts at way 0.
    do_miss($urandom, 1, 0, 3);
    way_log.delete();
    do_miss($urandom, 0, 2, -1);
    check("post_reset_way", 32'(way_log[0]), 32'd0);

`ifdef ICACHE_REFILL_PERF_EN
    do_reset();
    do_miss($urandom, 0, 0, -1);
    do_idle_cycle($urandom, 1'b1, 1'b0);
    do_miss($urandom, 1, 1, -1);
    do_idle_cycle($urandom, 1'b1, 1'b1);
    do_miss($urandom, 2, 2, -1);
    #1 check("perf_miss_cnt", miss_cnt, 32'd3);
`endif

    // Randomized mix of hits, stray handshakes and misses.
    repeat (30) begin
      case ($urandom_range(0, 3))
        0:       do_idle_cycle($urandom, 1'b1, 1'($urandom));
        1:       do_idle_cycle($urandom, 1'b0, 1'b1);
        default: do_miss($urandom, $urandom_range(0, 3), $urandom_range(0, 2), -1);
      endcase
    end

`ifdef ICACHE_REFILL_PERF_EN
    check("perf_miss_cnt_final", miss_cnt, 32'(model_misses));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameters SHALL be: WAY_NUM, default 4, number of ways; LINE_WORDS, default 8, 32-bit words per line; INDEX_W, default 7, set-index width.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req_valid  in  1  lookup valid this cycle.
REQ-006 req_addr  in  32  lookup byte address.
REQ-007 lookup_hit  in  1  tag compare hit for req_addr.
REQ-008 stall  out  1  hold the fetch pipeline.
REQ-009 rd_req  out  1  line read request to memory.
REQ-010 rd_addr  out  32  line-aligned read address.
REQ-011 rd_rdy  in  1  memory accepted rd_req.
REQ-012 ret_valid  in  1  returned word valid.
REQ-013 ret_data  in  32  returned word.
REQ-014 wr_en  out  1  data RAM write strobe.
REQ-015 wr_way  out  $clog2(WAY_NUM)  target way.
REQ-016 wr_index  out  INDEX_W  target set.
REQ-017 wr_offset  out  $clog2(LINE_WORDS)  word within line.
REQ-018 wr_data  out  32  word to write.
REQ-019 tag_wr  out  1  write tag and set valid for wr_way/wr_index.
REQ-020 tag_data  out  32-INDEX_W-$clog2(LINE_WORDS)-2  tag to write.
REQ-021 refill_done  out  1  one-cycle pulse at refill completion.

Function
REQ-022 The FSM SHALL have states IDLE, MISS, REFILL and DONE.
REQ-023 IDLE: req_valid=1 and lookup_hit=0 SHALL latch req_addr and the victim pointer and go to MISS; in all other cases the FSM SHALL stay in IDLE.
REQ-024 MISS: rd_req SHALL be 1, and rd_addr SHALL equal the latched address with bits [log2(LINE_WORDS)+1:0] zeroed; rd_rdy=1 SHALL go to REFILL.
REQ-025 REFILL: each cycle with ret_valid=1 SHALL produce wr_en=1 in that same cycle, with wr_data=ret_data, wr_offset=word counter, wr_way=latched victim and wr_index=latched index bits; the counter SHALL then increment.
REQ-026 REFILL: the word with counter = LINE_WORDS-1 SHALL go to DONE. Cycles with ret_valid=0 SHALL hold state and counter.
REQ-027 DONE: the block SHALL assert tag_wr=1 and refill_done=1 for exactly one cycle, clear the counter, advance the victim pointer, then go to IDLE.
REQ-028 The victim pointer SHALL advance round-robin, wrapping from WAY_NUM-1 to 0, and SHALL change only in DONE.
REQ-029 stall SHALL be 1 in MISS, REFILL and DONE, and SHALL be 1 combinationally in IDLE when req_valid=1 and lookup_hit=0; otherwise it SHALL be 0.
REQ-030 ret_valid outside REFILL SHALL be ignored, with no write.
REQ-031 rd_rdy outside MISS SHALL be ignored.
REQ-032 req_valid and lookup_hit SHALL be ignored in MISS, REFILL and DONE.

Reset
REQ-033 On rst, including mid-refill, the block SHALL enter IDLE, clear the counter, clear the victim pointer and the latched address, and drive all outputs to 0.
REQ-034 The block SHALL issue no wr_en or tag_wr after a reset until a new miss occurs.

Configuration
REQ-035 With ICACHE_REFILL_PERF_EN defined, the block SHALL provide output miss_cnt[31:0], reset to 0, incrementing once per IDLE->MISS transition and saturating at 32'hFFFFFFFF.
REQ-036 Without ICACHE_REFILL_PERF_EN, the miss_cnt port and its counter SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-037 Hit: req_valid=1, lookup_hit=1, addr 0x1000 -> the FSM stays in IDLE, stall=0, rd_req=0.
REQ-038 Miss with gaps: miss at 0x0000_1234, rd_rdy after 2 cycles, 8 ret_valid with 1-cycle gaps -> rd_addr=0x0000_1220; writes at offsets 0..7 to way 0, index 0x11; tag_wr and refill_done pulse once; tag_data=0x00001.
REQ-039 Round-robin: 5 consecutive misses -> wr_way sequence 0,1,2,3,0.
REQ-040 Reset mid-refill: assert rst after the 3rd returned word -> outputs 0, state IDLE, victim 0; the next miss uses way 0 from offset 0.
REQ-041 Stray inputs: ret_valid=1 and rd_rdy=1 while in IDLE -> no wr_en, and no state change.
REQ-042 Perf counter: with ICACHE_REFILL_PERF_EN, 3 misses and 2 hits -> miss_cnt=3.
